// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding three byte requesters into one shared UART sender.
// Define UART_TX_ARB_TIMEOUT_EN to abort a stuck frame after TIMEOUT cycles (sticky err).
module uart_tx_arbiter #(
  parameter logic [19:0] TIMEOUT = 20'd500000,
  parameter int          DW      = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [2:0]      req,
  input  logic [3*DW-1:0] req_data,
  output logic [2:0]      ack,
  output logic            tx_start,
  output logic [DW-1:0]   tx_data,
  input  logic            tx_busy,
  output logic [1:0]      grant_id,
  output logic            err,
  output logic [1:0]      dbg_state
);

  // Handshake: req[i] is a level held until ack[i] pulses for one cycle; that pulse
  // marks the byte as latched, and the requester may drop or re-raise req afterwards.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  if (TIMEOUT == 20'd0) begin : g_bad_timeout
    $error("uart_tx_arbiter: TIMEOUT must be nonzero");
  end

  state_t          state_q;
  logic [2:0]      ack_q;
  logic            tx_start_q;
  logic [DW-1:0]   tx_data_q;
  logic [1:0]      grant_q;
  logic            err_q;

  logic [1:0]      rr_base;
  logic            win_valid;
  logic [1:0]      win_idx;
  logic [DW-1:0]   win_data;

  function automatic logic [1:0] rr_add(input logic [1:0] b, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, b} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  assign rr_base = (grant_q == 2'd2) ? 2'd0 : grant_q + 2'd1;

  // Scan from farthest to nearest so the requester closest to rr_base wins.
  always_comb begin
    logic [1:0] cand;
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      cand = rr_add(rr_base, 2'(k));
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_data = req_data[32'(win_idx)*DW +: DW];

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [19:0] tmo_cnt_q;
  logic        tmo_hit;
  assign tmo_hit = (tmo_cnt_q == TIMEOUT - 20'd1);
`else
  logic        tmo_hit;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      grant_q    <= 2'd2;
      err_q      <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
    end else begin
      ack_q      <= '0;
      tx_start_q <= 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      tmo_cnt_q  <= '0;
`endif
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            ack_q     <= 3'b001 << win_idx;
            tx_data_q <= win_data;
            grant_q   <= win_idx;
            state_q   <= START;
          end
        end
        START: begin
          tx_start_q <= 1'b1;
          state_q    <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= WAIT_DONE;
          end else if (tmo_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 20'd1;
`endif
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state_q <= IDLE;
          end else if (tmo_hit) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
`ifdef UART_TX_ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_q + 20'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ack       = ack_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign grant_id  = grant_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: sender model, tx_data scoreboard, protocol monitor.
module tb_uart_tx_arbiter;
  localparam int DW = 8;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam logic [19:0] TMO      = 20'd16;
  localparam int          BUSY_LEN = 8;
`else
  localparam logic [19:0] TMO      = 20'd500000;
  localparam int          BUSY_LEN = 20;
`endif
  localparam int          BUSY_DLY = 3;
  localparam logic [1:0]  S_IDLE = 2'd0, S_START = 2'd1, S_WBUSY = 2'd2, S_WDONE = 2'd3;

  logic            CLK = 1'b0;
  logic            RST_N;
  logic [2:0]      req;
  logic [3*DW-1:0] req_data;
  logic [2:0]      ack;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic [1:0]      grant_id;
  logic            err;
  logic [1:0]      dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] exp_q[$];
  logic sender_en;
  int   s_cnt;

  uart_tx_arbiter #(.TIMEOUT(TMO), .DW(DW)) dut (
    .CLK(CLK), .RST_N(RST_N), .req(req), .req_data(req_data), .ack(ack),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .err(err), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sender model: busy rises BUSY_DLY cycles after tx_start, stays BUSY_LEN cycles
  always @(negedge CLK) begin
    if (!RST_N || !sender_en) begin
      tx_busy = 1'b0;
      s_cnt   = 0;
    end else if (s_cnt == 0) begin
      if (tx_start) s_cnt = 1;
    end else begin
      s_cnt++;
      tx_busy = (s_cnt >= BUSY_DLY) && (s_cnt < BUSY_DLY + BUSY_LEN);
      if (s_cnt >= BUSY_DLY + BUSY_LEN) s_cnt = 0;
    end
  end

  // monitor + scoreboard
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      check("ack_onehot", 32'($onehot0(ack)), 32'd1);
      if (ack !== 3'b000) check("ack_only_in_start", dbg_state, S_START);
      if (tx_start === 1'b1) begin
        if (exp_q.size() == 0) check("tx_start_unexpected", 32'd1, 32'd0);
        else check("tx_data", tx_data, exp_q.pop_front());
      end
    end
  end

  task automatic wait_state(input logic [1:0] st, input string tag);
    int n = 0;
    while (dbg_state !== st && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check(tag, dbg_state, st);
  endtask

  task automatic wait_ack(input logic [2:0] exp, input string tag);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (ack === 3'b000 && n < 200);
    check(tag, ack, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbg_state, S_IDLE);
    check({tag, "_ack"}, ack, 3'b000);
    check({tag, "_tx_start"}, tx_start, 1'b0);
    check({tag, "_tx_data"}, tx_data, 8'h00);
    check({tag, "_grant_id"}, grant_id, 2'd2);
    check({tag, "_err"}, err, 1'b0);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
  endtask

  logic [2:0] rr_order [4];
  int bad;
  int n;

  initial begin
    RST_N = 1'b0; req = '0; req_data = '0; sender_en = 1'b1;
    rr_order = '{3'b001, 3'b010, 3'b100, 3'b001};
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    RST_N = 1'b1;
    @(negedge CLK);

    // single requester 1
    req_data = {8'h30, 8'hA5, 8'h10};
    req = 3'b010;
    exp_q.push_back(8'hA5);
    @(negedge CLK);
    check("single_ack", ack, 3'b010);
    check("single_grant", grant_id, 2'd1);
    req = 3'b000;
    @(negedge CLK);
    check("single_tx_start", tx_start, 1'b1);
    check("single_ack_clear", ack, 3'b000);
    wait_state(S_WDONE, "single_wait_done");
    wait_state(S_IDLE, "single_idle");
    check("single_data_held", tx_data, 8'hA5);

    // all three held: round robin from reset
    do_reset();
    req_data = {8'h30, 8'h20, 8'h10};
    req = 3'b111;
    exp_q.push_back(8'h10); exp_q.push_back(8'h20);
    exp_q.push_back(8'h30); exp_q.push_back(8'h10);
    for (int i = 0; i < 4; i++) begin
      wait_ack(rr_order[i], "rr_ack");
      if (i == 3) req = 3'b000;
      wait_state(S_IDLE, "rr_idle");
    end
    check("rr_queue_drained", 32'(exp_q.size()), 32'd0);

    // req0 arrives during requester 2's frame
    req_data = {8'h3C, 8'h00, 8'h5C};
    req = 3'b100;
    exp_q.push_back(8'h3C);
    wait_ack(3'b100, "late_ack2");
    req = 3'b000;
    wait_state(S_WDONE, "late_wait_done");
    req = 3'b001;
    exp_q.push_back(8'h5C);
    bad = 0; n = 0;
    while (dbg_state !== S_IDLE && n < 200) begin
      if (ack !== 3'b000) bad++;
      @(negedge CLK);
      n++;
    end
    check("late_no_ack_in_frame", 32'(bad), 32'd0);
    check("late_idle_ack", ack, 3'b000);
    @(negedge CLK);
    check("late_ack0", ack, 3'b001);
    req = 3'b000;
    wait_state(S_IDLE, "late_idle");

    // reset during WAIT_DONE
    req_data = {8'h00, 8'h77, 8'h00};
    req = 3'b010;
    exp_q.push_back(8'h77);
    wait_ack(3'b010, "midrst_ack");
    req = 3'b000;
    wait_state(S_WDONE, "midrst_wait_done");
    RST_N = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    RST_N = 1'b1;
    repeat (10) @(negedge CLK);
    check("midrst_stays_idle", dbg_state, S_IDLE);
    check("midrst_queue", 32'(exp_q.size()), 32'd0);

    // tx_busy stuck low
    sender_en = 1'b0;
    req_data = {8'h00, 8'h42, 8'hE1};
    req = 3'b001;
    exp_q.push_back(8'hE1);
    wait_ack(3'b001, "stuck_ack");
    req = 3'b000;
    @(negedge CLK);
    check("stuck_tx_start", tx_start, 1'b1);
    check("stuck_state", dbg_state, S_WBUSY);
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    while (dbg_state === S_WBUSY && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("tmo_cycles", 32'(n), 32'd16);
    check("tmo_idle", dbg_state, S_IDLE);
    check("tmo_err", err, 1'b1);
    repeat (5) @(negedge CLK);
    check("tmo_err_sticky", err, 1'b1);
    sender_en = 1'b1;
    req = 3'b010;
    exp_q.push_back(8'h42);
    wait_ack(3'b010, "tmo_next_ack");
    req = 3'b000;
    wait_state(S_WDONE, "tmo_next_wait_done");
    wait_state(S_IDLE, "tmo_next_idle");
    check("tmo_next_err", err, 1'b1);
    check("tmo_next_grant", grant_id, 2'd1);
`else
    bad = 0;
    repeat (1000) begin
      @(negedge CLK);
      if (dbg_state !== S_WBUSY || err !== 1'b0) bad++;
    end
    check("stuck_hold_1000", 32'(bad), 32'd0);
    check("stuck_still_wbusy", dbg_state, S_WBUSY);
    check("stuck_err", err, 1'b0);
    do_reset();
    sender_en = 1'b1;
    req = 3'b010;
    exp_q.push_back(8'h42);
    wait_ack(3'b010, "recover_ack");
    req = 3'b000;
    wait_state(S_WDONE, "recover_wait_done");
    wait_state(S_IDLE, "recover_idle");
    check("recover_err", err, 1'b0);
`endif
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 20'd500000, CLK cycles allowed per busy phase before abort.
REQ-002 Parameter: DW, default 8, byte width.
REQ-003 Port: CLK  input  1  system clock; all logic on posedge CLK.
REQ-004 Port: RST_N  input  1  reset, synchronous, active-low.
REQ-005 Port: req  input  3  per-requester send request, level, held until matching ack.
REQ-006 Port: req_data  input  3*DW  {data2,data1,data0}, valid while corresponding req high.
REQ-007 Port: ack  output  3  one-cycle pulse, bit i when requester i's byte is latched.
REQ-008 Port: tx_start  output  1  one-cycle start pulse to the shared UART sender.
REQ-009 Port: tx_data  output  DW  byte to sender; stable from tx_start until return to IDLE.
REQ-010 Port: tx_busy  input  1  sender frame in progress; synchronous to CLK, may rise several cycles after tx_start.
REQ-011 Port: grant_id  output  2  index of last granted requester.
REQ-012 Port: err  output  1  sticky timeout flag.

Function
REQ-013 FSM states SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-014 IDLE: if any req bit high, select winner by round-robin starting at (grant_id+1) mod 3, latch its byte into tx_data, pulse ack[winner], update grant_id, go START; else stay.
REQ-015 Requester indices 0..2 only; wrap 2 -> 0; grant_id never takes value 3.
REQ-016 START: assert tx_start for exactly one cycle, go WAIT_BUSY.
REQ-017 WAIT_BUSY: on tx_busy=1 go WAIT_DONE; otherwise stay.
REQ-018 WAIT_DONE: on tx_busy=0 go IDLE; next grant earliest the cycle after IDLE is entered.
REQ-019 Latency req->ack SHALL be 1 cycle when in IDLE; ack->tx_start 1 cycle.
REQ-020 At most one ack bit high per cycle; no ack outside IDLE.
REQ-021 Requests arriving while not IDLE SHALL wait; none lost while req held.
REQ-022 req dropped before ack SHALL be ignored (no grant, no state effect).
REQ-023 Single requester SHALL be served back-to-back with no starvation of others: with all three held, grant order cycles 0,1,2,0,... from reset.
REQ-024 tx_busy already high in IDLE/START SHALL not alter sequencing (WAIT_BUSY exits on next busy=1 cycle).

Reset
REQ-025 RST_N=0 at a posedge SHALL force IDLE, ack=0, tx_start=0, tx_data=0, grant_id=2, err=0, timeout counter=0.
REQ-026 Reset mid-frame SHALL abandon the transfer with no further tx_start; requester is not re-acked unless it re-requests.

Configuration
REQ-027 Macro UART_TX_ARB_TIMEOUT_EN: when defined, a counter clears on each state entry and increments in WAIT_BUSY/WAIT_DONE; reaching TIMEOUT forces IDLE and sets err=1 until reset.
REQ-028 Without UART_TX_ARB_TIMEOUT_EN: no counter, WAIT states wait indefinitely, err tied 0.

Verification
REQ-029 Reset, req=3'b010, data1=8'hA5; sender model busy 3 cycles after start for 20 cycles -> ack=3'b010 one cycle, tx_start one cycle later, tx_data=8'hA5 held, grant_id=1, back to IDLE after busy falls.
REQ-030 req=3'b111 held, data 8'h10/8'h20/8'h30 -> tx_data sequence 8'h10, 8'h20, 8'h30, 8'h10; each ack once per frame.
REQ-031 req0 asserted during WAIT_DONE of requester 2 -> ack[0] exactly one cycle after IDLE re-entered; no pulse during frame.
REQ-032 RST_N low during WAIT_DONE -> next cycle IDLE, all outputs reset values, no tx_start.
REQ-033 With UART_TX_ARB_TIMEOUT_EN, TIMEOUT=16, tx_busy stuck 0 -> after 16 cycles in WAIT_BUSY FSM returns to IDLE, err=1 sticky, next request served normally.
REQ-034 Without macro, same stimulus -> FSM stays WAIT_BUSY for 1000 cycles, err=0.
